// File: rtl/config_update_queue.sv
// In-order config update queue that paces writes into a downstream config register.
// Writes are issued one at a time, with a programmable number of idle cycles between them.
module config_update_queue #(
  parameter int width = 1,
  parameter int depth = 4,
  parameter int gap   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enq,
  input  logic [width-1:0]       d_in,
  output logic                   full_n,
  input  logic                   hold,
  output logic                   en,
  output logic [width-1:0]       d_out,
  output logic                   empty_n,
  output logic [$clog2(depth):0] count,
  output logic                   err
);

  localparam int PW = $clog2(depth);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [3:0]    GAP_C   = 4'(gap);

  logic [width-1:0] mem_q [depth];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             en_q, en_d, err_q, err_d;
  logic [width-1:0] d_out_q, d_out_d;
  logic             enq_ok, issue;

  // Both flags come from the registered count only, so a full queue refuses
  // an enqueue even in a cycle where an issue frees an entry.
  assign full_n  = (count_q != DEPTH_C);
  assign empty_n = (count_q != '0);

  always_comb begin
    enq_ok    = enq && full_n;
    issue     = empty_n && !hold && (gap_cnt_q == 4'd0);
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    gap_cnt_d = gap_cnt_q;
    en_d      = issue;
    d_out_d   = d_out_q;
    err_d     = err_q;

    if (enq_ok) tail_d = tail_q + PTR_ONE;

    // Hold only blocks issue; the spacing timer keeps running underneath it.
    if (issue) begin
      head_d    = head_q + PTR_ONE;
      d_out_d   = mem_q[head_q];
      gap_cnt_d = GAP_C;
    end else if (gap_cnt_q != 4'd0) begin
      gap_cnt_d = gap_cnt_q - 4'd1;
    end

    case ({enq_ok, issue})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (enq && !full_n) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      gap_cnt_q <= 4'd0;
      en_q      <= 1'b0;
      d_out_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      gap_cnt_q <= gap_cnt_d;
      en_q      <= en_d;
      d_out_q   <= d_out_d;
      err_q     <= err_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (enq_ok) mem_q[tail_q] <= d_in;
  end

  assign en    = en_q;
  assign d_out = d_out_q;
  assign count = count_q;
  assign err   = err_q;

endmodule

// File: doc/config_update_queue.md
CONFIG_UPDATE_QUEUE -- requirements
Module: config_update_queue

Interface
REQ-001 Parameter width, default 1: data width of each config update; it SHALL match the width of the downstream config register.
REQ-002 Parameter depth, default 4: number of buffered updates; it SHALL be a power of 2 in the range 2..16.
REQ-003 Parameter gap, default 0: minimum idle cycles between issued updates; it SHALL be in the range 0..15.
REQ-004 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 RST_N  input  1  reset, asynchronous and active-low.
REQ-006 ENQ  input  1  update request, sampled on the CLK rising edge.
REQ-007 D_IN  input  width  update value, qualified by ENQ.
REQ-008 FULL_N  output  1  high when the queue can accept an update.
REQ-009 HOLD  input  1  high when the downstream config register must not be written this cycle.
REQ-010 EN  output  1  write enable to the downstream config register.
REQ-011 D_OUT  output  width  write data to the downstream config register.
REQ-012 EMPTY_N  output  1  high when at least one update is pending.
REQ-013 COUNT  output  log2(depth)+1  number of pending updates.
REQ-014 ERR  output  1  sticky overflow flag.

Function
REQ-015 The block SHALL be a FIFO of depth entries, with in-order issue and no coalescing.
REQ-016 An enqueue SHALL occur when ENQ=1 and FULL_N=1 at a CLK edge; the block SHALL write D_IN to the tail entry.
REQ-017 ENQ=1 while FULL_N=0 SHALL be dropped, SHALL not alter the queue, and SHALL set ERR=1 at that edge.
REQ-018 FULL_N SHALL be computed from the registered COUNT only: FULL_N = (COUNT != depth).
- A full queue SHALL NOT accept an enqueue, even if an issue occurs in the same cycle.
REQ-019 Issue condition in a cycle: EMPTY_N=1, HOLD=0 and the gap counter equal to 0.
- On the following edge the block SHALL pop the head entry, set EN=1, and set D_OUT to the head value.
REQ-020 EN SHALL be registered and high for exactly one cycle per issued update.
REQ-021 D_OUT SHALL hold the last issued value while EN=0.
REQ-022 Gap counter, on each issue:
- it SHALL be loaded with gap;
- otherwise, while nonzero, it SHALL decrement by 1 per cycle;
- with gap=0, issues SHALL occur on consecutive cycles.
REQ-023 HOLD=1 SHALL suppress issue but SHALL NOT stop the gap counter decrementing.
REQ-024 Latency:
- ENQ is accepted at edge k into an empty queue with HOLD=0 and the gap counter at 0.
- EMPTY_N=1 and COUNT=1 SHALL appear after edge k.
- EN=1 SHALL appear after edge k+1.
REQ-025 Simultaneous enqueue and issue SHALL leave COUNT unchanged.
REQ-026 Head and tail pointers SHALL wrap modulo depth.
REQ-027 COUNT SHALL saturate at neither bound; REQ-017 and REQ-019 make COUNT<0 and COUNT>depth unreachable.
REQ-028 ERR SHALL remain 1 until reset.

Reset
REQ-029 RST_N=0 SHALL asynchronously force:
- FULL_N=1, EMPTY_N=0, COUNT=0;
- EN=0, D_OUT=0, ERR=0;
- gap counter=0, head and tail pointers=0.
REQ-030 Reset mid-operation SHALL discard all pending updates; no EN pulse SHALL occur for them after reset release.
REQ-031 FIFO storage entries SHALL NOT be reset.
REQ-032 The first edge with RST_N=1 SHALL be able to accept an enqueue.

Verification
REQ-033 The bench SHALL cover single update (width=8): ENQ D_IN=0x5A at edge 1 -> COUNT=1 after edge 1; EN=1 with D_OUT=0x5A after edge 2; EN=0, COUNT=0, D_OUT=0x5A after edge 3.
REQ-034 The bench SHALL cover fill and overflow (depth=4, HOLD=1): 5 consecutive ENQ of values 1..5 -> FULL_N=0 after the 4th; the 5th is dropped and ERR=1. Then HOLD=0 -> EN pulses on 4 consecutive cycles with D_OUT 1,2,3,4.
REQ-035 The bench SHALL cover gap spacing (gap=2): 3 queued updates with HOLD=0 -> EN high on cycles n, n+3, n+6 only.
REQ-036 The bench SHALL cover the full queue with simultaneous issue: queue full, HOLD=0, ENQ=1 -> issue occurs, enqueue dropped, ERR=1, COUNT=3.
REQ-037 The bench SHALL cover wrap-around: 10 alternating single ENQ/issue pairs with values 0..9 -> D_OUT sequence 0..9 with no loss or reordering.
REQ-038 The bench SHALL cover mid-operation reset: RST_N pulsed low with COUNT=3 -> outputs at reset values immediately, no EN after release, and a new ENQ 0xA5 issues 0xA5.
